// File: rtl/exec_sequencer.sv
// Multi-cycle signed add/sub/mul/div sequencer between keypad control and the result path.
// Build option EXEC_SATURATE_EN: clamp overflowing results instead of wrapping them.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for execute; operands sampled here only
// LOAD  | magnitudes, result sign and add/sub sum formed from latched operands
// MUL   | one shift-add step per cycle on magnitudes, WIDTH cycles
// DIV   | one restoring-divide step per cycle on magnitudes, WIDTH cycles
// FIX   | sign applied, range checked, result and flags registered
// DONE  | done pulse, back to IDLE
module exec_sequencer #(
   parameter int WIDTH = 16,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             execute,
   input  logic             abort,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             overflow,
   output logic             div_zero
);

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   localparam logic [2*WIDTH-1:0] MAG_MAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic [2*WIDTH-1:0] MAG_MIN = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
`ifdef EXEC_SATURATE_EN
   localparam logic [WIDTH-1:0]   RES_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0]   RES_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_MUL,
      S_DIV,
      S_FIX,
      S_DONE
   } state_t;

   state_t             state;
   logic [WIDTH-1:0]   a_reg;
   logic [WIDTH-1:0]   b_reg;
   logic [1:0]         op_reg;
   logic               neg_res;
   logic [WIDTH:0]     sum_reg;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH:0]     mag_b;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   quo;
   logic [CNT_W-1:0]   cnt;

   logic [WIDTH:0]     a_ext;
   logic [WIDTH:0]     b_ext;
   logic [WIDTH:0]     abs_a;
   logic [WIDTH:0]     abs_b;
   logic [WIDTH:0]     sum_nxt;
   logic [WIDTH:0]     div_shift;
   logic               div_ge;
   logic [WIDTH-1:0]   div_diff;
   logic [2*WIDTH-1:0] mag_full;
   logic               ovf_md;
   logic [WIDTH-1:0]   wrap_md;
   logic               fix_ovf;
   logic [WIDTH-1:0]   fix_wrap;
   logic [WIDTH-1:0]   fix_res;
`ifdef EXEC_SATURATE_EN
   logic               fix_neg;
`endif

   // Magnitudes carry one extra bit so that |-2^(WIDTH-1)| is representable.
   always_comb begin
      a_ext   = {a_reg[WIDTH-1], a_reg};
      b_ext   = {b_reg[WIDTH-1], b_reg};
      abs_a   = a_reg[WIDTH-1] ? -a_ext : a_ext;
      abs_b   = b_reg[WIDTH-1] ? -b_ext : b_ext;
      sum_nxt = (op_reg == OP_SUB) ? (a_ext - b_ext) : (a_ext + b_ext);
   end

   // Restoring step: the partial remainder never reaches the divisor, so the
   // low WIDTH bits of the difference are exact whenever the subtract is kept.
   always_comb begin
      div_shift = {rem, quo[WIDTH-1]};
      div_ge    = (div_shift >= mag_b);
      div_diff  = div_shift[WIDTH-1:0] - mag_b[WIDTH-1:0];
   end

   always_comb begin
      mag_full = (op_reg == OP_MUL) ? prod : {{WIDTH{1'b0}}, quo};
      ovf_md   = neg_res ? (mag_full > MAG_MIN) : (mag_full > MAG_MAX);
      wrap_md  = neg_res ? -mag_full[WIDTH-1:0] : mag_full[WIDTH-1:0];
      fix_ovf  = op_reg[1] ? ovf_md : (sum_reg[WIDTH] ^ sum_reg[WIDTH-1]);
      fix_wrap = op_reg[1] ? wrap_md : sum_reg[WIDTH-1:0];
`ifdef EXEC_SATURATE_EN
      fix_neg  = op_reg[1] ? neg_res : sum_reg[WIDTH];
      fix_res  = fix_ovf ? (fix_neg ? RES_MIN : RES_MAX) : fix_wrap;
`else
      fix_res  = fix_wrap;
`endif
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= S_IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         result   <= '0;
         overflow <= 1'b0;
         div_zero <= 1'b0;
         a_reg    <= '0;
         b_reg    <= '0;
         op_reg   <= OP_ADD;
         neg_res  <= 1'b0;
         sum_reg  <= '0;
         mcand    <= '0;
         mplier   <= '0;
         prod     <= '0;
         mag_b    <= '0;
         rem      <= '0;
         quo      <= '0;
         cnt      <= '0;
      end else if (abort && (state != S_IDLE)) begin
         // Cancel leaves the last completed result and flags untouched.
         state <= S_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         cnt   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (execute && !abort) begin
                  a_reg  <= a_in;
                  b_reg  <= b_in;
                  op_reg <= op;
                  busy   <= 1'b1;
                  state  <= S_LOAD;
               end
            end
            S_LOAD: begin
               neg_res <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1];
               sum_reg <= sum_nxt;
               mcand   <= {{(WIDTH-1){1'b0}}, abs_a};
               mplier  <= abs_b[WIDTH-1:0];
               prod    <= '0;
               mag_b   <= abs_b;
               rem     <= '0;
               quo     <= abs_a[WIDTH-1:0];
               case (op_reg)
                  OP_MUL: begin
                     cnt   <= CNT_W'(WIDTH);
                     state <= S_MUL;
                  end
                  OP_DIV: begin
                     if (b_reg == '0) begin
                        result   <= '0;
                        overflow <= 1'b0;
                        div_zero <= 1'b1;
                        done     <= 1'b1;
                        state    <= S_DONE;
                     end else begin
                        cnt   <= CNT_W'(WIDTH);
                        state <= S_DIV;
                     end
                  end
                  default: state <= S_FIX;
               endcase
            end
            S_MUL: begin
               if (mplier[0]) begin
                  prod <= prod + mcand;
               end
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  state <= S_FIX;
               end
            end
            S_DIV: begin
               rem <= div_ge ? div_diff : div_shift[WIDTH-1:0];
               quo <= {quo[WIDTH-2:0], div_ge};
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  state <= S_FIX;
               end
            end
            S_FIX: begin
               result   <= fix_res;
               overflow <= fix_ovf;
               div_zero <= 1'b0;
               done     <= 1'b1;
               state    <= S_DONE;
            end
            S_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
- Multi-cycle arithmetic sequencer between the keypad control FSM and the result register/display path.
- On an execute pulse it latches operands A and B and an op code, then runs add/sub (single pass), shift-add multiply or restoring divide.
- It returns a signed result with overflow and divide-by-zero flags, plus busy and done status back to control.

Parameters:
- WIDTH, 16, operand/result width in bits (signed two's complement, minimum 4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clock  input  1  system clock, all logic on posedge.
- reset  input  1  synchronous, active-high; returns block to IDLE and clears outputs.
- execute  input  1  start pulse from control; sampled only in IDLE.
- abort  input  1  cancel request (driven by the user reset key); sampled in every state.
- op  input  2  operation: 00 add, 01 sub, 10 mul, 11 div.
- a_in  input  WIDTH  operand A, signed.
- b_in  input  WIDTH  operand B, signed.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse, result and flags valid from this cycle on.
- result  output  WIDTH  signed result, held until the next done.
- overflow  output  1  result did not fit in WIDTH signed; held with result.
- div_zero  output  1  division with b=0; held with result.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, result=0, overflow=0, div_zero=0; counter and internal registers cleared.
- States: IDLE, LOAD, MUL, DIV, FIX, DONE. Output busy = (state != IDLE).
- IDLE:
  - execute=1 and abort=0 → latch a_in, b_in, op; go to LOAD.
  - Otherwise stay in IDLE.
- LOAD:
  - Compute |a|, |b| (WIDTH+1 bits so |-2^(W-1)| is exact) and result sign.
  - add/sub → FIX, computed with a WIDTH+1-bit signed sum.
  - mul → MUL with counter=WIDTH.
  - div with b=0 → DONE with div_zero=1, result=0, overflow=0.
  - div with b≠0 → DIV with counter=WIDTH.
- MUL: one shift-add step per cycle on the magnitudes into a 2*WIDTH-bit product; counter decrements; at counter=1 go to FIX. Exactly WIDTH cycles.
- DIV: one restoring-divide step per cycle on the magnitudes, producing quotient bits MSB first; exactly WIDTH cycles; then FIX. Quotient truncates toward zero; remainder is discarded.
- FIX:
  - Apply the sign (mul/div sign = sign_a XOR sign_b).
  - overflow=1 when the exact signed value lies outside [-2^(W-1), 2^(W-1)-1].
  - Register result and flags; div_zero=0; go to DONE.
- DONE: done=1 for exactly this cycle; next state IDLE.
- Latency, with execute sampled at cycle T:
  - add/sub: done at T+3.
  - mul/div: done at T+WIDTH+3.
  - div by zero: done at T+2.
  - busy is high from T+1 through the done cycle inclusive.
- execute while busy is ignored and not queued. New operands may be applied in the cycle done is high; they are captured only by the next execute in IDLE.
- abort in any non-IDLE state → IDLE on the next edge.
  - No done pulse.
  - result and flags keep their previous values.
  - Counter is cleared.
- abort in IDLE: no effect. execute and abort together in IDLE: abort wins and execute is dropped.
- reset has priority over abort and execute in every state, including mid-MUL/DIV.
- Operand inputs are not sampled after IDLE; changes during busy do not affect the result.

Optional Feature:
- Macro EXEC_SATURATE_EN.
- Defined: on overflow, result clamps to 2^(W-1)-1 if the true value is positive, else -2^(W-1); overflow flag is still set.
- Undefined: on overflow, result is the low WIDTH bits of the exact value (wrap); overflow flag set.
- Timing is identical in both builds.

Test Plan:
- Add wrap (WIDTH=16): add 30000 + 5000 → done at T+3; overflow=1; result 0x88B8 (wrap) or 0x7FFF (EXEC_SATURATE_EN); div_zero=0.
- Multiply: mul -123 × 45 → busy high T+1..T+19; done at T+19 only; result 0xEA61 (-5535); overflow=0. Then mul 300 × 300 → overflow=1, result 0x5F90 (wrap) / 0x7FFF (sat).
- Divide: div -7 / 2 → result 0xFFFD (-3), done at T+19. div 100 / 0 → done at T+2, div_zero=1, result 0, overflow=0.
- Divide overflow: div -32768 / -1 → overflow=1; result 0x8000 (wrap) / 0x7FFF (sat). Also mul -32768 × 1 → 0x8000, overflow=0.
- Abort: start mul, assert abort at T+8 → busy=0 at T+9, no done, result/flags equal the previous operation's. A second execute pulsed at T+4 (while busy) → ignored.
- Reset mid-op: reset during DIV at T+10 → next cycle all outputs 0, state IDLE; execute at T+12 runs normally.
